// File: rtl/axi_pwm_custom_pkg.sv
// axi_pwm_custom_pkg: shared FSM encodings and default sizing for the PWM ramp controller
package axi_pwm_custom_pkg;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_WIDTH = 12;
    localparam int DEF_PRESCALE_WIDTH = 16;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
endpackage

// File: rtl/axi_pwm_custom_tick_gen.sv
// axi_pwm_custom_tick_gen: ramp prescaler, one tick every prescale+1 enabled cycles
module axi_pwm_custom_tick_gen #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      pwm_clk,
    input  logic                      pwm_rst,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      tick
);
    logic [PRESCALE_WIDTH-1:0] cnt;
    assign tick = enable && cnt == prescale;
    // wrapping on >= keeps the counter bounded if prescale shrinks mid-count
    always_ff @(posedge pwm_clk or posedge pwm_rst)
        if (pwm_rst) cnt <= '0;
        else cnt <= (!enable || cnt >= prescale) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/axi_pwm_custom_ramp_ctrl.sv
// axi_pwm_custom_ramp_ctrl: steps each channel's duty toward its target once per tick,
// committing the whole set to the PWM outputs on a period boundary.
module axi_pwm_custom_ramp_ctrl
    import axi_pwm_custom_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
    input  logic                         pwm_clk,
    input  logic                         pwm_rst,
    input  logic                         enable,
    input  logic [PRESCALE_WIDTH-1:0]    prescale,
    input  logic [DATA_WIDTH-1:0]        step,
    input  logic [NUM_CH*DATA_WIDTH-1:0] target,
    input  logic                         target_valid,
    input  logic                         period_end,
    output logic [NUM_CH*DATA_WIDTH-1:0] duty,
    output logic                         busy,
    output logic                         done
);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int TW = NUM_CH * DATA_WIDTH;
    logic [1:0] state;
    logic [IW-1:0] idx;
    logic [TW-1:0] pending, active, working;
    logic [DATA_WIDTH-1:0] cur, tgt, diff, nxt;
    logic tick, last;

    axi_pwm_custom_tick_gen #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_tick (
        .pwm_clk (pwm_clk),
        .pwm_rst (pwm_rst),
        .enable  (enable),
        .prescale(prescale),
        .tick    (tick)
    );

    assign busy = working != active;
    assign cur = working[idx*DATA_WIDTH +: DATA_WIDTH];
    assign tgt = active[idx*DATA_WIDTH +: DATA_WIDTH];
    assign last = idx == IW'(NUM_CH - 1);

    always_comb begin
        diff = tgt > cur ? tgt - cur : cur - tgt;
        nxt = (step == '0 || diff <= step) ? tgt : tgt > cur ? cur + step : cur - step;
    end

    always_ff @(posedge pwm_clk or posedge pwm_rst)
        if (pwm_rst) begin
            state <= ST_IDLE;
            idx <= '0;
            pending <= '0;
            active <= '0;
            working <= '0;
            duty <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (target_valid) pending <= target;
            // new targets only take effect between passes so a pass never mixes old and new
            if (state == ST_IDLE) active <= pending;
            if (!enable) begin
                state <= ST_IDLE;
                idx <= '0;
            end else if (state == ST_IDLE) begin
                idx <= '0;
                if (tick && busy) state <= ST_UPDATE;
            end else if (state == ST_UPDATE) begin
                working[idx*DATA_WIDTH +: DATA_WIDTH] <= nxt;
                idx <= idx + 1'b1;
                if (last) state <= ST_COMMIT;
            end else if (state == ST_COMMIT) begin
                if (period_end) begin
                    duty <= working;
                    done <= !busy;
                    state <= ST_IDLE;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
endmodule

// File: doc/axi_pwm_custom_ramp_ctrl.md
AXI_PWM_CUSTOM_RAMP_CTRL -- requirements
Module: axi_pwm_custom_ramp_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of PWM channels sequenced.
REQ-002 Parameter DATA_WIDTH, default 12, duty value width per channel.
REQ-003 Parameter PRESCALE_WIDTH, default 16, ramp tick prescaler width.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous, active-high.
REQ-005 pwm_clk  in  1  sole clock; all state on rising edge.
REQ-006 pwm_rst  in  1  asynchronous active-high reset.
REQ-007 enable  in  1  ramp engine enable, level.
REQ-008 prescale  in  PRESCALE_WIDTH  tick period = prescale+1 cycles.
REQ-009 step  in  DATA_WIDTH  max duty change per channel per tick; 0 = jump to target.
REQ-010 target  in  NUM_CH*DATA_WIDTH  packed target duties, channel 0 in LSBs.
REQ-011 target_valid  in  1  single-cycle strobe capturing target.
REQ-012 period_end  in  1  PWM period boundary strobe from the PWM interface.
REQ-013 duty  out  NUM_CH*DATA_WIDTH  committed duties, packed like target, to PWM data_channel inputs.
REQ-014 busy  out  1  high while any working duty differs from its captured target.
REQ-015 done  out  1  single-cycle pulse when all channels reach target and are committed.

Function
REQ-016 Tick counter SHALL count 0..prescale while enable=1, emitting tick when count==prescale, then wrap to 0; enable=0 holds counter at 0.
REQ-017 target_valid SHALL load a pending register; pending SHALL transfer to active targets only in IDLE; a strobe in other states is held until IDLE (latest strobe wins).
REQ-018 FSM states: IDLE, UPDATE, COMMIT.
REQ-019 IDLE -> UPDATE on tick when busy=1; ticks with busy=0 are ignored.
REQ-020 UPDATE SHALL process one channel per cycle, index 0..NUM_CH-1, then -> COMMIT (exactly NUM_CH cycles).
REQ-021 Channel update: diff=|target-working|; if step==0 or diff<=step, working=target, else working moves toward target by step; unsigned, no overflow or underflow.
REQ-022 COMMIT SHALL wait for period_end=1; on that cycle duty<=working on the next edge, then -> IDLE.
REQ-023 period_end outside COMMIT SHALL be ignored; ticks arriving in UPDATE/COMMIT SHALL be dropped, not queued.
REQ-024 done SHALL pulse on the cycle after the commit that makes working==target for all channels; never while busy remains 1.
REQ-025 enable deassertion in any state SHALL return the FSM to IDLE next edge; duty holds; working keeps partial progress.
REQ-026 busy SHALL be combinational compare of working vs active target.
REQ-027 Latency tick -> duty change: NUM_CH+1 cycles minimum, plus wait for period_end.

Reset
REQ-028 On pwm_rst: duty, working, active and pending targets = 0; tick counter = 0; state IDLE; busy=0; done=0.
REQ-029 Reset assertion mid-UPDATE or mid-COMMIT SHALL discard the cycle's work with no partial duty update; release is synchronous to pwm_clk.

Structure
REQ-030 Shared package axi_pwm_custom_pkg SHALL hold FSM state encodings and default DATA_WIDTH/NUM_CH constants.
REQ-031 Sub-module axi_pwm_custom_tick_gen SHALL implement the prescaler (REQ-016).
REQ-032 Block SHALL sit between the up_adc_channel register outputs and axi_pwm_custom_if, with no AXI logic of its own.

Verification
REQ-033 Reset, prescale=3, step=256, target ch0=1024, period_end every 8 cycles -> duty0 steps 256,512,768,1024, then done pulses once.
REQ-034 step=0, target all=4095 -> one commit sets all duty=4095; done pulses; busy falls.
REQ-035 working=1000, target=990, step=16 -> one update lands exactly 990; no underflow.
REQ-036 target_valid during UPDATE with new ch1=200 -> current pass uses old target; next IDLE adopts 200.
REQ-037 period_end held low 100 cycles in COMMIT -> duty unchanged, ticks dropped; first period_end commits.
REQ-038 pwm_rst asserted mid-UPDATE -> all outputs 0 same cycle asynchronously; FSM IDLE after release.
